// File: rtl/noc_pkg.sv
// Shared NoC flit format, output-port encodings and the dimension-ordered XY routing function.
package noc_pkg;

    localparam int XY_W      = 4;
    localparam int DATAW     = 16;
    localparam int FLIT_HEAD = 15;
    localparam int FLIT_TAIL = 14;
    localparam int PORT_W    = 3;

    localparam logic [PORT_W-1:0] PORT_LOCAL = 3'd0;
    localparam logic [PORT_W-1:0] PORT_EAST  = 3'd1;
    localparam logic [PORT_W-1:0] PORT_WEST  = 3'd2;
    localparam logic [PORT_W-1:0] PORT_NORTH = 3'd3;
    localparam logic [PORT_W-1:0] PORT_SOUTH = 3'd4;

    typedef struct packed {
        logic             valid;
        logic [DATAW-1:0] data;
        logic             vch;
    } router_i_t;

    // X is resolved completely before Y, which keeps XY routing deadlock-free on a mesh.
    function automatic logic [PORT_W-1:0] xy_route(input logic [XY_W-1:0] dst_x,
                                                   input logic [XY_W-1:0] dst_y,
                                                   input logic [XY_W-1:0] my_x,
                                                   input logic [XY_W-1:0] my_y);
        logic [PORT_W-1:0] port;
        if (dst_x > my_x)      port = PORT_EAST;
        else if (dst_x < my_x) port = PORT_WEST;
        else if (dst_y > my_y) port = PORT_NORTH;
        else if (dst_y < my_y) port = PORT_SOUTH;
        else                   port = PORT_LOCAL;
        return port;
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit FIFO with registered storage; a push at full is only taken
// when a pop frees the slot in the same cycle.
module vc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full,
    output logic             pop_ok
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    assign data_out = mem_q[rd_q];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (pop_ok)  rd_d = rd_q + 1'b1;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
        else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push_ok) mem_q[wr_q] <= data_in;
        end
    end

endmodule

// File: rtl/vc_input_buffer.sv
// Router input port: demuxes flits into two VC FIFOs, routes each packet XY from its head flit,
// and returns one credit upstream per accepted pop.
module vc_input_buffer
    import noc_pkg::*;
#(
    parameter int              DEPTH = 4,
    parameter logic [XY_W-1:0] MY_X  = '0,
    parameter logic [XY_W-1:0] MY_Y  = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  router_i_t                  flit_i,
    input  logic      [1:0]            pop_i,
    output router_i_t [1:0]            vc_o,
    output logic      [1:0]            req_o,
    output logic      [1:0][PORT_W-1:0] port_o,
    output logic      [1:0]            credit_o,
    output logic                       ovf_o
);

    logic [1:0]             push;
    logic [1:0]             empty;
    logic [1:0]             full;
    logic [1:0]             pop_ok;
    logic [DATAW:0]         head_q [2];
    logic [1:0][PORT_W-1:0] route_c;
    logic [1:0][PORT_W-1:0] route_q, route_d;
    logic [1:0]             in_pkt_q, in_pkt_d;
    logic [1:0]             is_head, is_tail;
    logic                   ovf_q, ovf_d;

    for (genvar g = 0; g < 2; g++) begin : g_vc
        vc_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (DATAW + 1)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push[g]),
            .data_in  ({flit_i.vch, flit_i.data}),
            .pop      (pop_i[g]),
            .data_out (head_q[g]),
            .empty    (empty[g]),
            .full     (full[g]),
            .pop_ok   (pop_ok[g])
        );
    end

    always_comb begin
        push     = '0;
        route_c  = '0;
        is_head  = '0;
        is_tail  = '0;
        vc_o     = '0;
        req_o    = '0;
        port_o   = '0;
        credit_o = '0;
        route_d  = route_q;
        in_pkt_d = in_pkt_q;
        for (int v = 0; v < 2; v++) begin
            push[v]    = flit_i.valid && (flit_i.vch == v[0]);
            route_c[v] = xy_route(head_q[v][XY_W-1:0], head_q[v][2*XY_W-1:XY_W], MY_X, MY_Y);
            is_head[v] = ~empty[v] & head_q[v][FLIT_HEAD];
            is_tail[v] = ~empty[v] & head_q[v][FLIT_TAIL];
            // Head flits route themselves; body/tail flits follow the route latched at head pop.
            port_o[v]   = is_head[v] ? route_c[v] : route_q[v];
            req_o[v]    = ~empty[v];
            credit_o[v] = pop_ok[v];
            if (!empty[v]) begin
                vc_o[v].valid = 1'b1;
                vc_o[v].data  = head_q[v][DATAW-1:0];
                vc_o[v].vch   = head_q[v][DATAW];
            end
            if (pop_ok[v] && is_head[v]) route_d[v] = route_c[v];
            if (pop_ok[v]) begin
                if (is_tail[v])      in_pkt_d[v] = 1'b0;
                else if (is_head[v]) in_pkt_d[v] = 1'b1;
            end
        end
        ovf_d = ovf_q | |(push & full & ~pop_ok);
        ovf_o = ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            route_q  <= {PORT_LOCAL, PORT_LOCAL};
            in_pkt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            route_q  <= route_d;
            in_pkt_q <= in_pkt_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
